mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined integer multiplier (32x32 -> 64, interface intA/intB/val_op/oprand_rdy/commit/longP) between NREQ independent requesters.
- Round-robin arbitration; registered issue stage drives the multiplier.
- In-order tag FIFO records the requester ID of each in-flight operation and steers each commit result back to its owner.
- Sits between client blocks and the multiplier core; shares the multiplier's clk/reset.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, requester-ID width; must satisfy 2**IDW >= NREQ.
- DEPTH, 8, tag FIFO entries = max operations in flight (issued, not yet committed); power of 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_val  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- req_rdy  out  NREQ  one-hot grant; transfer when req_val[i]&req_rdy[i].
- resp_val  out  NREQ  one-cycle result pulse to the owner requester.
- resp_p  out  64  product, broadcast; valid where resp_val[i]=1.
- intA  out  32  multiplier operand A (registered).
- intB  out  32  multiplier operand B (registered).
- val_op  out  1  multiplier operand valid (registered).
- oprand_rdy  in  1  multiplier accepts operand this cycle.
- commit  in  1  multiplier result valid (one-cycle pulse, in issue order).
- longP  in  64  multiplier result.
- busy  out  1  issue register or FIFO non-empty.
- err_underflow  out  1  sticky: commit with empty tag FIFO.

Behaviour:
- Reset values: req_rdy=0, resp_val=0, resp_p=0, intA=intB=0, val_op=0, busy=0, err_underflow=0, RR pointer=0, FIFO empty, inflight count=0.
- Issue register holds {intA, intB, val_op, tag}.
- Multiplier handshake: operation accepted when val_op&oprand_rdy.
- While val_op=1 and oprand_rdy=0, intA/intB/tag are held stable.
- slot_free = !val_op | oprand_rdy.
- space = (fifo_count + val_op) < DEPTH.
- Grant: when slot_free & space, pick the first i with req_val[i]=1 scanning from ptr upward, modulo NREQ.
- req_rdy is combinational: only the granted bit is high. With no grant, req_rdy=0.
- On grant at edge k: issue register loads req_a[i]/req_b[i], tag=i, val_op=1; ptr <= (i+1) mod NREQ.
- Without a grant: if oprand_rdy accepted the op, val_op <= 0; otherwise hold.
- Back-to-back: accept and new grant in the same cycle gives a continuous val_op with no bubble.
- Tag FIFO push: tag is written at the multiplier accept edge (val_op&oprand_rdy).
- Tag FIFO pop: on commit, pop the head; at the same edge resp_p <= longP and resp_val <= onehot(head). resp_val is deasserted the next cycle unless another commit occurs.
- Latency: requester transfer -> val_op 1 cycle; commit -> resp_val 1 cycle.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance.
- Pointers wrap modulo DEPTH.
- Full (count+val_op==DEPTH): no grants. An already-valid issue register may still be accepted by the multiplier.
- Commit on empty FIFO (including a same-cycle push into an empty FIFO): err_underflow <= 1 (sticky until reset), resp_val stays 0, count unchanged.
- No response backpressure: requesters must sink resp_val.
- Reset mid-operation: all in-flight tags are discarded; the multiplier shares the reset, so no stale commits are expected.

Test Plan:
- Single requester 0 sends (3,5) -> val_op 1 cycle later with intA=3, intB=5; after commit with longP=15 -> resp_val=2'b01, resp_p=15 next cycle.
- Both requesters hold req_val=11 continuously, oprand_rdy=1 -> grants alternate 01,10,01,10; results return to the matching requester in order: (2,7)->14 to req0, (4,4)->16 to req1.
- oprand_rdy low for 3 cycles with val_op=1 -> intA/intB stable, req_rdy=0, no push; accepted on the 4th cycle, then the next grant proceeds.
- Withhold commits with DEPTH=8 -> exactly 8 ops issued, then req_rdy=0; one commit -> exactly one further grant.
- commit pulsed with FIFO empty -> err_underflow=1 held, resp_val=0; reset clears it.
- Assert reset with 3 ops in flight -> all outputs return to reset values immediately; after release the first request is granted to requester 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one pipelined 32x32 multiplier among NREQ requesters
module mul_share_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDW   = 1,
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_val,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   output logic [NREQ-1:0]      req_rdy,
   output logic [NREQ-1:0]      resp_val,
   output logic [63:0]          resp_p,
   output logic [31:0]          intA,
   output logic [31:0]          intB,
   output logic                 val_op,
   input  logic                 oprand_rdy,
   input  logic                 commit,
   input  logic [63:0]          longP,
   output logic                 busy,
   output logic                 err_underflow
);

   // DEPTH is a power of two (>= 2), so pointers wrap naturally at AW bits
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // issue register
   logic [31:0]      inta_q, inta_d;
   logic [31:0]      intb_q, intb_d;
   logic             val_op_q, val_op_d;
   logic [IDW-1:0]   tag_q, tag_d;
   logic [IDW-1:0]   ptr_q, ptr_d;

   // tag FIFO
   logic [IDW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   // response side
   logic [NREQ-1:0]  resp_val_q, resp_val_d;
   logic [63:0]      resp_p_q, resp_p_d;
   logic             err_q, err_d;

   logic             accept;
   logic             slot_free;
   logic             space;
   logic             gnt_found;
   logic [IDW-1:0]   gnt_id;
   logic             grant;
   logic [31:0]      sel_a;
   logic [31:0]      sel_b;
   logic             push;
   logic             pop;
   logic             underflow;
   logic [IDW-1:0]   head_tag;

   assign accept    = val_op_q & oprand_rdy;
   assign slot_free = !val_op_q | oprand_rdy;
   // issue register counts against capacity so a full FIFO never overflows on its accept
   assign space     = (32'(count_q) + 32'(val_op_q)) < DEPTH;
   assign grant     = !reset & slot_free & space & gnt_found;

   // round-robin scan: first valid requester at or after ptr, modulo NREQ
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_val[i] && (((int'(ptr_q) + k) % NREQ) == i)) begin
               gnt_found = 1'b1;
               gnt_id    = IDW'(i);
            end
         end
      end
   end

   // one-hot grant and operand select for the winning requester
   always_comb begin
      req_rdy = '0;
      sel_a   = '0;
      sel_b   = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_rdy[i] = grant && (gnt_id == IDW'(i));
         if (gnt_id == IDW'(i)) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   // issue register next state: load on grant, drop valid once accepted, otherwise hold
   always_comb begin
      inta_d   = inta_q;
      intb_d   = intb_q;
      val_op_d = val_op_q;
      tag_d    = tag_q;
      ptr_d    = ptr_q;
      if (grant) begin
         inta_d   = sel_a;
         intb_d   = sel_b;
         val_op_d = 1'b1;
         tag_d    = gnt_id;
         ptr_d    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end else if (accept) begin
         val_op_d = 1'b0;
      end
   end

   assign push      = accept;
   assign pop       = commit && (count_q != '0);
   // a same-cycle push cannot satisfy a commit: the result would precede its own issue
   assign underflow = commit && (count_q == '0);
   assign head_tag  = mem_q[head_q];

   // tag FIFO pointers and the response to the head owner
   always_comb begin
      head_d     = pop  ? head_q + AW'(1) : head_q;
      tail_d     = push ? tail_q + AW'(1) : tail_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      resp_p_d   = pop ? longP : resp_p_q;
      err_d      = err_q | underflow;
      resp_val_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_val_d[i] = pop && (head_tag == IDW'(i));
      end
   end

   // all control state, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inta_q     <= '0;
         intb_q     <= '0;
         val_op_q   <= 1'b0;
         tag_q      <= '0;
         ptr_q      <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         resp_val_q <= '0;
         resp_p_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         inta_q     <= inta_d;
         intb_q     <= intb_d;
         val_op_q   <= val_op_d;
         tag_q      <= tag_d;
         ptr_q      <= ptr_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         resp_val_q <= resp_val_d;
         resp_p_q   <= resp_p_d;
         err_q      <= err_d;
      end
   end

   // tag storage needs no reset: entries are only read between push and pop
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[tail_q] <= tag_q;
      end
   end

   assign intA          = inta_q;
   assign intB          = intb_q;
   assign val_op        = val_op_q;
   assign resp_val      = resp_val_q;
   assign resp_p        = resp_p_q;
   assign busy          = val_op_q | (count_q != '0);
   assign err_underflow = err_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;

   logic          clk;
   logic          reset;
   logic [1:0]    req_val;
   logic [63:0]   req_a;
   logic [63:0]   req_b;
   logic [1:0]    req_rdy;
   logic [1:0]    resp_val;
   logic [63:0]   resp_p;
   logic [31:0]   intA;
   logic [31:0]   intB;
   logic          val_op;
   logic          oprand_rdy;
   logic          commit;
   logic [63:0]   longP;
   logic          busy;
   logic          err_underflow;

   mul_share_arbiter #(.NREQ(2), .IDW(1), .DEPTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_val       (req_val),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_rdy       (req_rdy),
      .resp_val      (resp_val),
      .resp_p        (resp_p),
      .intA          (intA),
      .intB          (intB),
      .val_op        (val_op),
      .oprand_rdy    (oprand_rdy),
      .commit        (commit),
      .longP         (longP),
      .busy          (busy),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [63:0] p;
   } exp_t;

   typedef struct {
      int          kind;
      logic [63:0] val;
      string       name;
   } probe_t;

   localparam int P_RDY   = 0;
   localparam int P_VALOP = 1;
   localparam int P_INTA  = 2;
   localparam int P_INTB  = 3;
   localparam int P_BUSY  = 4;
   localparam int P_ERR   = 5;
   localparam int P_RVAL  = 6;
   localparam int P_RP    = 7;
   localparam int P_EXPQ  = 8;

   exp_t        expq[$];
   probe_t      pq[$];
   logic [63:0] mq[$];
   int          checks = 0;
   int          errors = 0;
   logic        auto_commit;
   logic        man_commit_req;

   // multiplier stand-in: capture product on accept, return it later as a commit
   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
      end else if (val_op && oprand_rdy) begin
         mq.push_back(64'(intA) * 64'(intB));
      end
      #2;
      if (reset) begin
         commit = 1'b0;
         longP  = '0;
      end else if (man_commit_req || (auto_commit && mq.size() > 0)) begin
         commit = 1'b1;
         if (mq.size() > 0) longP = mq.pop_front();
         else               longP = 64'hDEAD;
      end else begin
         commit = 1'b0;
      end
   end

   // monitor: scoreboard on responses, then any pending point probes
   always @(negedge clk) begin
      exp_t        e;
      probe_t      pr;
      logic [1:0]  oh;
      logic [63:0] act;
      if (resp_val != 2'b00) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp resp_val=%b resp_p=%h required no response", resp_val, resp_p);
         end else begin
            e  = expq.pop_front();
            oh = 2'b01 << e.id;
            if (resp_val !== oh || resp_p !== e.p) begin
               errors++;
               $display("FAIL resp got val=%b p=%h required val=%b p=%h", resp_val, resp_p, oh, e.p);
            end
         end
      end
      while (pq.size() > 0) begin
         pr = pq.pop_front();
         case (pr.kind)
            P_RDY:   act = 64'(req_rdy);
            P_VALOP: act = 64'(val_op);
            P_INTA:  act = 64'(intA);
            P_INTB:  act = 64'(intB);
            P_BUSY:  act = 64'(busy);
            P_ERR:   act = 64'(err_underflow);
            P_RVAL:  act = 64'(resp_val);
            P_RP:    act = resp_p;
            default: act = 64'(expq.size());
         endcase
         checks++;
         if (act !== pr.val) begin
            errors++;
            $display("FAIL %s got %h required %h", pr.name, act, pr.val);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int kind, input logic [63:0] v, input string nm);
      probe_t p;
      p.kind = kind;
      p.val  = v;
      p.name = nm;
      pq.push_back(p);
   endtask

   task automatic expect_resp(input int id, input logic [63:0] p);
      exp_t e;
      e.id = id;
      e.p  = p;
      expq.push_back(e);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (expq.size() != 0 && n < 40) begin
         step();
         n++;
      end
      probe(P_EXPQ, 64'd0, nm);
      step();
   endtask

   initial begin
      reset          = 1'b1;
      req_val        = 2'b00;
      req_a          = '0;
      req_b          = '0;
      oprand_rdy     = 1'b1;
      commit         = 1'b0;
      longP          = '0;
      auto_commit    = 1'b1;
      man_commit_req = 1'b0;

      // reset state, with requests pending to show grants are held off
      step();
      req_val = 2'b11;
      probe(P_RDY, 64'd0, "reset_rdy");
      probe(P_VALOP, 64'd0, "reset_valop");
      probe(P_INTA, 64'd0, "reset_inta");
      probe(P_BUSY, 64'd0, "reset_busy");
      probe(P_ERR, 64'd0, "reset_err");
      probe(P_RVAL, 64'd0, "reset_rval");
      step();
      req_val = 2'b00;
      reset   = 1'b0;
      step();

      // single request (3,5) from requester 0
      req_val = 2'b01; req_a[31:0] = 32'd3; req_b[31:0] = 32'd5;
      probe(P_RDY, 64'h1, "t1_rdy");
      expect_resp(0, 64'd15);
      step();
      req_val = 2'b00;
      probe(P_VALOP, 64'd1, "t1_valop");
      probe(P_INTA, 64'd3, "t1_inta");
      probe(P_INTB, 64'd5, "t1_intb");
      probe(P_BUSY, 64'd1, "t1_busy");
      drain("t1_drain");
      probe(P_BUSY, 64'd0, "t1_idle");

      // both requesting continuously; pointer sits at 1 so requester 1 goes first
      req_val = 2'b11;
      req_a = {32'd4, 32'd2}; req_b = {32'd4, 32'd7};
      probe(P_RDY, 64'h2, "t2_rdy0");
      expect_resp(1, 64'd16);
      step();
      req_a = {32'd6, 32'd2}; req_b = {32'd9, 32'd7};
      probe(P_RDY, 64'h1, "t2_rdy1");
      probe(P_VALOP, 64'd1, "t2_valop1");
      expect_resp(0, 64'd14);
      step();
      probe(P_RDY, 64'h2, "t2_rdy2");
      probe(P_VALOP, 64'd1, "t2_valop2");
      expect_resp(1, 64'd54);
      step();
      req_a = {32'd6, 32'hFFFF_FFFF}; req_b = {32'd9, 32'hFFFF_FFFF};
      probe(P_RDY, 64'h1, "t2_rdy3");
      probe(P_VALOP, 64'd1, "t2_valop3");
      expect_resp(0, 64'hFFFF_FFFE_0000_0001);
      step();
      req_val = 2'b00;
      drain("t2_drain");

      // multiplier stalls three cycles with an op pending
      req_val = 2'b01; req_a[31:0] = 32'd10; req_b[31:0] = 32'd11;
      oprand_rdy = 1'b0;
      probe(P_RDY, 64'h1, "t3_rdy");
      expect_resp(0, 64'd110);
      for (int s = 0; s < 3; s++) begin
         step();
         req_val = 2'b11;
         req_a = {32'd12, 32'd99}; req_b = {32'd12, 32'd99};
         probe(P_RDY, 64'h0, "t3_stall_rdy");
         probe(P_INTA, 64'd10, "t3_stall_inta");
         probe(P_INTB, 64'd11, "t3_stall_intb");
      end
      step();
      oprand_rdy = 1'b1;
      req_val = 2'b10;
      probe(P_RDY, 64'h2, "t3_next_rdy");
      expect_resp(1, 64'd144);
      step();
      req_val = 2'b00;
      probe(P_INTA, 64'd12, "t3_next_inta");
      drain("t3_drain");

      // commits withheld: exactly DEPTH ops go out, then one commit frees one slot
      auto_commit = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         req_val = 2'b01; req_a[31:0] = 32'(k); req_b[31:0] = 32'd3;
         if (k <= 8) begin
            probe(P_RDY, 64'h1, "t4_fill_rdy");
            expect_resp(0, 64'(3 * k));
         end else begin
            probe(P_RDY, 64'h0, "t4_full_rdy");
         end
         step();
      end
      man_commit_req = 1'b1;
      req_a[31:0] = 32'd9;
      probe(P_RDY, 64'h0, "t4_commit_rdy");
      step();
      man_commit_req = 1'b0;
      probe(P_RDY, 64'h1, "t4_refill_rdy");
      expect_resp(0, 64'd27);
      step();
      probe(P_RDY, 64'h0, "t4_full2_rdy");
      step();
      probe(P_RDY, 64'h0, "t4_full3_rdy");
      step();
      req_val = 2'b00;
      auto_commit = 1'b1;
      drain("t4_drain");

      // commit with nothing in flight
      man_commit_req = 1'b1;
      step();
      man_commit_req = 1'b0;
      probe(P_ERR, 64'd1, "t5_err");
      probe(P_RVAL, 64'd0, "t5_rval");
      step();
      probe(P_ERR, 64'd1, "t5_err_sticky");
      step();

      // reset with three ops in flight
      auto_commit = 1'b0;
      req_val = 2'b11;
      req_a = {32'd8, 32'd8}; req_b = {32'd8, 32'd8};
      probe(P_RDY, 64'h2, "t6_rdy0");
      step();
      probe(P_RDY, 64'h1, "t6_rdy1");
      step();
      probe(P_RDY, 64'h2, "t6_rdy2");
      step();
      req_val = 2'b00;
      reset   = 1'b1;
      probe(P_VALOP, 64'd0, "t6_rst_valop");
      probe(P_INTA, 64'd0, "t6_rst_inta");
      probe(P_INTB, 64'd0, "t6_rst_intb");
      probe(P_BUSY, 64'd0, "t6_rst_busy");
      probe(P_ERR, 64'd0, "t6_rst_err");
      probe(P_RVAL, 64'd0, "t6_rst_rval");
      probe(P_RP, 64'd0, "t6_rst_rp");
      step();
      reset = 1'b0;
      step();
      req_val = 2'b11;
      req_a = {32'd6, 32'd5}; req_b = {32'd6, 32'd5};
      probe(P_RDY, 64'h1, "t6_post_rdy");
      expect_resp(0, 64'd25);
      step();
      req_val = 2'b00;
      auto_commit = 1'b1;
      drain("t6_drain");
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
